// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request/response front end for one single-port masked sync-read SRAM macro.
// Define SRAM_REQ_CTRL_INIT_CLEAR_EN to zero-fill the array after reset before any request is accepted.
module sram_req_ctrl #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 20,
    parameter int MASK_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    logic              init_active;
    logic [ADDR_W-1:0] init_addr;
    logic              rd_inflight, hold_valid, read_ok, fire;
    logic [DATA_W-1:0] hold_data;

    if (DEPTH > (1 << ADDR_W) || DATA_W % MASK_W != 0) begin : g_param_check
        $error("sram_req_ctrl: DEPTH must fit ADDR_W and DATA_W must divide evenly by MASK_W");
    end

`ifdef SRAM_REQ_CTRL_INIT_CLEAR_EN
    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
    state_t state, state_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            init_addr <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_addr <= init_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_next  = state == IDLE ? INIT :
                      (state == INIT && init_addr == ADDR_W'(DEPTH - 1)) ? RUN : state;
        init_active = state == INIT;
        init_done   = state == RUN;
    end
`else
    logic done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) done_q <= 1'b0;
        else done_q <= 1'b1;
    end

    assign init_active = 1'b0;
    assign init_addr   = '0;
    assign init_done   = done_q;
`endif

    // A read may only issue when its response has somewhere to go next cycle.
    assign read_ok    = init_done & ~hold_valid & ~(rd_inflight & ~resp_ready);
    assign req_ready  = init_done & (req_write | read_ok);
    assign fire       = req_valid & req_ready;
    assign sram_en    = init_active | fire;
    assign sram_wmode = init_active | req_write;
    assign sram_addr  = init_active ? init_addr : req_addr;
    assign sram_wmask = init_active ? '1 : req_wmask;
    assign sram_wdata = init_active ? '0 : req_wdata;
    assign resp_valid = hold_valid | rd_inflight;
    assign resp_data  = hold_valid ? hold_data : sram_rdata;

    // Capture happens on the same edge as any write accepted during the stall, so the held data is pre-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_inflight <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
        end else begin
            rd_inflight <= fire & ~req_write;
            if (rd_inflight & ~resp_ready) begin
                hold_valid <= 1'b1;
                hold_data  <= sram_rdata;
            end else if (resp_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench for sram_req_ctrl with a behavioural masked SRAM macro attached.
// Covers both builds; with SRAM_REQ_CTRL_INIT_CLEAR_EN the array model starts dirty to prove the clear.
module tb_sram_req_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [6:0]  req_addr = '0;
    logic [3:0]  req_wmask = '0;
    logic [19:0] req_wdata = '0;
    logic        req_ready, resp_valid, init_done, sram_en, sram_wmode;
    logic [19:0] resp_data, sram_wdata;
    logic [19:0] sram_rdata = '0;
    logic [6:0]  sram_addr;
    logic [3:0]  sram_wmask;
    logic [19:0] mem [128];
    int          checks = 0, errors = 0;

    always #5 clock = ~clock;

    sram_req_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_addr(sram_addr), .sram_wmask(sram_wmask), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // Macro model: rdata only changes on a read enable.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int g = 0; g < 4; g++)
                    if (sram_wmask[g]) mem[sram_addr][g*5 +: 5] <= sram_wdata[g*5 +: 5];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [6:0] a, input logic [3:0] m, input logic [19:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
`ifdef SRAM_REQ_CTRL_INIT_CLEAR_EN
        for (int i = 0; i < 128; i++) mem[i] <= 20'hFFFFF;
`else
        for (int i = 0; i < 128; i++) mem[i] <= 20'h00000;
`endif
        req_write = 1'b1;
        cyc();
        cyc();
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_resp_valid", resp_valid, 0);
        reset_n = 1'b1;
        #1;
`ifdef SRAM_REQ_CTRL_INIT_CLEAR_EN
        check("post_rst_sram_en", sram_en, 0);
        issue(1'b1, 7'd3, 4'hF, 20'h55555);
        for (int i = 0; i < 128; i++) begin
            cyc();
            check("init_addr", sram_addr, i);
            check("init_wdata", sram_wdata, 0);
            check("init_ctl", {sram_en, sram_wmode, sram_wmask, req_ready, resp_valid, init_done}, 9'b1_1_1111_0_0_0);
        end
        idle();
        cyc();
        check("init_done_129", init_done, 1);
        check("run_sram_en_idle", sram_en, 0);
`else
        idle();
        cyc();
        check("init_done_first_edge", init_done, 1);
`endif
        // Write then read back with a ready consumer.
        issue(1'b1, 7'd5, 4'hF, 20'hABCDE);
        #1;
        check("wr_ready", req_ready, 1);
        check("wr_port", {sram_en, sram_wmode, sram_addr, sram_wmask}, {1'b1, 1'b1, 7'd5, 4'hF});
        check("wr_wdata", sram_wdata, 20'hABCDE);
        cyc();
        issue(1'b0, 7'd5, 4'h0, 20'h0);
        #1;
        check("rd_ready", req_ready, 1);
        check("rd_port", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, 7'd5});
        check("rd_no_early_valid", resp_valid, 0);
        cyc();
        idle();
        check("rd_valid", resp_valid, 1);
        check("rd_data", resp_data, 20'hABCDE);
        cyc();
        check("rd_valid_one_cycle", resp_valid, 0);
        // Masked write over zeroed entry.
        issue(1'b1, 7'd9, 4'b0101, 20'h12345);
        cyc();
        issue(1'b0, 7'd9, 4'h0, 20'h0);
        cyc();
        idle();
        check("mask_valid", resp_valid, 1);
        check("mask_data", resp_data, 20'h02005);
        cyc();
        // Stalled response; write slips past it; held data is pre-write.
        resp_ready = 1'b0;
        issue(1'b0, 7'd5, 4'h0, 20'h0);
        #1;
        check("stall_rd_ready", req_ready, 1);
        cyc();
        issue(1'b0, 7'd6, 4'h0, 20'h0);
        #1;
        check("stall_rd_blocked", req_ready, 0);
        check("stall_no_en", sram_en, 0);
        check("stall_valid", resp_valid, 1);
        check("stall_data", resp_data, 20'hABCDE);
        issue(1'b1, 7'd5, 4'hF, 20'h11111);
        #1;
        check("stall_wr_ready", req_ready, 1);
        check("stall_wr_en", sram_en, 1);
        cyc();
        idle();
        #1;
        check("hold_rd_blocked", req_ready, 0);
        check("hold_valid", resp_valid, 1);
        check("hold_data", resp_data, 20'hABCDE);
        cyc();
        check("hold_data_2", resp_data, 20'hABCDE);
        resp_ready = 1'b1;
        #1;
        check("hold_drain_valid", resp_valid, 1);
        check("hold_drain_data", resp_data, 20'hABCDE);
        check("hold_drain_rd_blocked", req_ready, 0);
        cyc();
        check("drained_valid", resp_valid, 0);
        check("drained_rd_ready", req_ready, 1);
        issue(1'b0, 7'd5, 4'h0, 20'h0);
        cyc();
        idle();
        check("post_wr_valid", resp_valid, 1);
        check("post_wr_data", resp_data, 20'h11111);
        cyc();
        // Back-to-back reads of distinct values.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 7'(i), 4'hF, 20'hA0000 | 20'(i));
            cyc();
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 7'(i), 4'h0, 20'h0);
            #1;
            check("b2b_ready", req_ready, 1);
            if (i > 0) begin
                check("b2b_valid", resp_valid, 1);
                check("b2b_data", resp_data, 20'hA0000 | 20'(i - 1));
            end
            cyc();
        end
        idle();
        check("b2b_last_valid", resp_valid, 1);
        check("b2b_last_data", resp_data, 20'hA0007);
        cyc();
        check("b2b_done", resp_valid, 0);
        // Reset while a response is held.
        resp_ready = 1'b0;
        issue(1'b0, 7'd3, 4'h0, 20'h0);
        cyc();
        idle();
        cyc();
        issue(1'b1, 7'd1, 4'hF, 20'h0);
        #1;
        check("pre_rst_held", resp_valid, 1);
        check("pre_rst_data", resp_data, 20'hA0003);
        check("pre_rst_wr_ready", req_ready, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_en", sram_en, 0);
        check("mid_rst_init_done", init_done, 0);
        idle();
        cyc();
        reset_n = 1'b1;
`ifdef SRAM_REQ_CTRL_INIT_CLEAR_EN
        cyc();
        check("reinit_addr0", {sram_en, sram_addr}, {1'b1, 7'd0});
        check("reinit_valid", resp_valid, 0);
        cyc();
        check("reinit_addr1", {sram_en, sram_addr}, {1'b1, 7'd1});
`else
        cyc();
        check("rerun_init_done", init_done, 1);
        check("rerun_valid", resp_valid, 0);
        cyc();
        check("rerun_valid_2", resp_valid, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
